// File: rtl/sdram_req_seq.sv
// sdram_req_seq: expands one user read/write request into the SDRAM
// controller command sequence ACTIVE -> READ/WRITE -> PRECHARGE and
// produces the read-data valid window with a last-beat marker.
//
// Build option: define AUTO_PRECHARGE_EN to issue READ/WRITE with
// auto-precharge (row_addr[10] = 1) and drop the explicit PRECHARGE stage.
//
// Handshakes: a transfer happens in a cycle where valid && ready are both
// sampled high at the rising edge. The producer holds valid and its payload
// stable until that cycle. On the user side req_ready is the ready; on the
// controller side cmd_valid is the valid and it always drops for at least
// one cycle after each transfer.
module sdram_req_seq #(
    parameter int ROW_WD = 13,
    parameter int COL_WD = 10,
    parameter int BA_WD  = 2,
    parameter int LEN_WD = 12,
    parameter int RD_LAT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_wr,
    input  logic [BA_WD+ROW_WD+COL_WD-1:0] req_addr,
    input  logic [LEN_WD-1:0]             req_len,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [3:0]                    cmd,
    output logic [ROW_WD-1:0]             row_addr,
    output logic [COL_WD-1:0]             col_addr,
    output logic [BA_WD-1:0]              cmd_ba,
    output logic [LEN_WD-1:0]             r_cmd_len,
    output logic [LEN_WD-1:0]             w_cmd_len,
    input  logic [15:0]                   r_data,
    output logic [15:0]                   rd_data,
    output logic                          rd_valid,
    output logic                          rd_last,
    output logic                          busy
);

    localparam logic [3:0] CMD_ACT = 4'd5;
    localparam logic [3:0] CMD_RD  = 4'd6;
    localparam logic [3:0] CMD_WR  = 4'd7;
    localparam logic [3:0] CMD_PRE = 4'd2;
    // Latency counter only needs to hold RD_LAT-1.
    localparam int LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT);
`ifdef AUTO_PRECHARGE_EN
    localparam logic [ROW_WD-1:0] A10_BIT = ROW_WD'(1) << 10;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACT  = 3'd1,
        S_RW   = 3'd2,
        S_PRE  = 3'd3,
        S_WAIT = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_gap;
    logic                r_wr;
    logic [BA_WD-1:0]    r_ba;
    logic [ROW_WD-1:0]   r_row;
    logic [COL_WD-1:0]   r_col;
    logic [LEN_WD-1:0]   r_len;
    logic                r_lat_run;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [LEN_WD-1:0]   r_beats_left;
    logic                r_rd_valid;
    logic                r_rd_last;
    logic [15:0]         r_rd_data;
    logic                w_cmd_valid;
    logic                w_fire;
    logic                w_accept;
    logic                w_rd_fire;
`ifndef AUTO_PRECHARGE_EN
    logic                r_rd_done;
    logic                w_rd_ok;
`endif

    // A command is presented in any command state except the cycle right
    // after a fire, which forces the mandatory bubble.
    assign w_cmd_valid = ((r_state == S_ACT) || (r_state == S_RW) || (r_state == S_PRE)) && !r_gap;
    assign w_fire      = w_cmd_valid && cmd_ready;
    assign w_accept    = (r_state == S_IDLE) && req_valid;
    assign w_rd_fire   = (r_state == S_RW) && w_fire && !r_wr;
`ifndef AUTO_PRECHARGE_EN
    // A read may finish before the PRECHARGE fire; the write never waits.
    assign w_rd_ok     = r_wr || r_rd_done || r_rd_last;
`endif

    assign cmd_valid = w_cmd_valid;
    assign req_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign rd_valid  = r_rd_valid;
    assign rd_last   = r_rd_last;
    assign rd_data   = r_rd_data;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and command field decode.
    always_comb begin
        w_next    = r_state;
        cmd       = '0;
        row_addr  = '0;
        col_addr  = '0;
        cmd_ba    = '0;
        r_cmd_len = '0;
        w_cmd_len = '0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) w_next = S_ACT;
            end
            S_ACT: begin
                cmd      = CMD_ACT;
                row_addr = r_row;
                cmd_ba   = r_ba;
                if (w_fire) w_next = S_RW;
            end
            S_RW: begin
                cmd = r_wr ? CMD_WR : CMD_RD;
`ifdef AUTO_PRECHARGE_EN
                row_addr = A10_BIT;
`endif
                col_addr = r_col;
                cmd_ba   = r_ba;
                if (r_wr) w_cmd_len = r_len;
                else      r_cmd_len = r_len;
                if (w_fire) begin
`ifdef AUTO_PRECHARGE_EN
                    w_next = r_wr ? S_IDLE : S_WAIT;
`else
                    w_next = S_PRE;
`endif
                end
            end
`ifndef AUTO_PRECHARGE_EN
            S_PRE: begin
                cmd    = CMD_PRE;
                cmd_ba = r_ba;
                if (w_fire) w_next = w_rd_ok ? S_IDLE : S_WAIT;
            end
`endif
            S_WAIT: begin
                if (r_rd_last) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Post-fire bubble flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gap <= 1'b0;
        end else begin
            r_gap <= w_fire;
        end
    end

    // Request latch; the column is passed through untouched (wraps in-page).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= 1'b0;
            r_ba  <= '0;
            r_row <= '0;
            r_col <= '0;
            r_len <= '0;
        end else if (w_accept) begin
            r_wr  <= req_wr;
            r_ba  <= req_addr[BA_WD+ROW_WD+COL_WD-1 -: BA_WD];
            r_row <= req_addr[ROW_WD+COL_WD-1 -: ROW_WD];
            r_col <= req_addr[COL_WD-1:0];
            r_len <= req_len;
        end
    end

`ifndef AUTO_PRECHARGE_EN
    // Remembers that the last read beat already went out before PRECHARGE fired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_done <= 1'b0;
        end else if (w_accept) begin
            r_rd_done <= 1'b0;
        end else if (r_rd_last) begin
            r_rd_done <= 1'b1;
        end
    end
`endif

    // Read window: wait RD_LAT cycles after the READ fire, then register
    // len+1 beats of r_data, flagging the final one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_run    <= 1'b0;
            r_lat_cnt    <= '0;
            r_beats_left <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            if (r_rd_valid) begin
                if (r_rd_last) begin
                    r_rd_valid <= 1'b0;
                    r_rd_last  <= 1'b0;
                    r_rd_data  <= '0;
                end else begin
                    r_rd_data    <= r_data;
                    r_rd_last    <= (r_beats_left == LEN_WD'(1));
                    r_beats_left <= r_beats_left - LEN_WD'(1);
                end
            end
            if (r_lat_run) begin
                if (r_lat_cnt == LAT_W'(1)) begin
                    r_lat_run  <= 1'b0;
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= r_data;
                    r_rd_last  <= (r_beats_left == '0);
                end else begin
                    r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                end
            end
            if (w_rd_fire) begin
                r_beats_left <= r_len;
                if (RD_LAT == 1) begin
                    r_rd_valid <= 1'b1;
                    r_rd_data  <= r_data;
                    r_rd_last  <= (r_len == '0);
                end else begin
                    r_lat_run <= 1'b1;
                    r_lat_cnt <= LAT_W'(RD_LAT - 1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_req_seq.sv
// tb_sdram_req_seq: bench for sdram_req_seq. A negedge monitor keeps a
// small model of the request lifecycle; expected commands are queued when
// a request is accepted and popped on each controller fire.
module tb_sdram_req_seq;

    localparam int ROW_WD = 13;
    localparam int COL_WD = 10;
    localparam int BA_WD  = 2;
    localparam int LEN_WD = 12;
    localparam int RD_LAT = 4;

    logic                          clk;
    logic                          rst_n;
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_wr;
    logic [BA_WD+ROW_WD+COL_WD-1:0] req_addr;
    logic [LEN_WD-1:0]             req_len;
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [3:0]                    cmd;
    logic [ROW_WD-1:0]             row_addr;
    logic [COL_WD-1:0]             col_addr;
    logic [BA_WD-1:0]              cmd_ba;
    logic [LEN_WD-1:0]             r_cmd_len;
    logic [LEN_WD-1:0]             w_cmd_len;
    logic [15:0]                   r_data;
    logic [15:0]                   rd_data;
    logic                          rd_valid;
    logic                          rd_last;
    logic                          busy;

    sdram_req_seq #(
        .ROW_WD(ROW_WD), .COL_WD(COL_WD), .BA_WD(BA_WD), .LEN_WD(LEN_WD), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_len(req_len),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .row_addr(row_addr), .col_addr(col_addr), .cmd_ba(cmd_ba),
        .r_cmd_len(r_cmd_len), .w_cmd_len(w_cmd_len),
        .r_data(r_data), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .busy(busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Packed command: {cmd[52:49], row[48:36], col[35:26], ba[25:24], rlen[23:12], wlen[11:0]}
    logic [52:0] exp_q[$];

    function automatic logic [52:0] pack_cmd(input logic [3:0] c, input logic [12:0] r,
                                             input logic [9:0] co, input logic [1:0] b,
                                             input logic [11:0] rl, input logic [11:0] wl);
        return {c, r, co, b, rl, wl};
    endfunction

    task automatic push_req(input logic wr, input logic [1:0] b, input logic [12:0] r,
                            input logic [9:0] co, input logic [11:0] l);
        logic [12:0] rw_row;
`ifdef AUTO_PRECHARGE_EN
        rw_row = 13'h0400;
`else
        rw_row = 13'h0000;
`endif
        exp_q.push_back(pack_cmd(4'd5, r, 10'd0, b, 12'd0, 12'd0));
        exp_q.push_back(pack_cmd(wr ? 4'd7 : 4'd6, rw_row, co, b,
                                 wr ? 12'd0 : l, wr ? l : 12'd0));
`ifndef AUTO_PRECHARGE_EN
        exp_q.push_back(pack_cmd(4'd2, 13'd0, 10'd0, b, 12'd0, 12'd0));
`endif
    endtask

    // ---------------- monitor / model ----------------
    bit          m_busy, m_wr, m_cmds_done, m_rd_done, m_win_on;
    int          cyc, win_start, win_end;
    logic        prev_valid, prev_fire;
    logic [15:0] prev_rdata;

    always @(negedge clk) begin
        bit          busy_now, in_win, last_now, fire;
        logic [52:0] obs_cmd, e;
        if (!rst_n) begin
            m_busy = 0; m_wr = 0; m_cmds_done = 0; m_rd_done = 0; m_win_on = 0;
            prev_valid = 0; prev_fire = 0; prev_rdata = '0;
            exp_q.delete();
        end else begin
            cyc++;
            busy_now = m_busy;
            check_val("req_ready", 64'(req_ready), 64'(!busy_now));
            check_val("busy", 64'(busy), 64'(busy_now));
            in_win   = m_win_on && (cyc >= win_start) && (cyc <= win_end);
            last_now = in_win && (cyc == win_end);
            check_val("rd_valid", 64'(rd_valid), 64'(in_win));
            check_val("rd_last", 64'(rd_last), 64'(last_now));
            if (in_win) check_val("rd_data", 64'(rd_data), 64'(prev_rdata));
            if (prev_fire)       check_val("cmd_gap", 64'(cmd_valid), 64'(0));
            else if (prev_valid) check_val("cmd_hold", 64'(cmd_valid), 64'(1));
            if (!busy_now) check_val("idle_cmd_valid", 64'(cmd_valid), 64'(0));
            fire = cmd_valid && cmd_ready;
            if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_cmd", 64'(cmd_valid), 64'(0));
                end else begin
                    obs_cmd = {cmd, row_addr, col_addr, cmd_ba, r_cmd_len, w_cmd_len};
                    check_val("cmd_fields", 64'(obs_cmd), 64'(exp_q[0]));
                    if (fire) begin
                        e = exp_q.pop_front();
                        if (e[52:49] == 4'd6) begin
                            m_win_on  = 1;
                            win_start = cyc + RD_LAT;
                            win_end   = cyc + RD_LAT + int'(e[23:12]);
                        end
                        if (exp_q.size() == 0) m_cmds_done = 1;
                    end
                end
            end
            if (last_now) begin
                m_rd_done = 1;
                m_win_on  = 0;
            end
            if (busy_now && m_cmds_done && (m_wr || m_rd_done)) m_busy = 0;
            if (!busy_now && req_valid) begin
                m_busy = 1; m_wr = req_wr; m_cmds_done = 0; m_rd_done = 0;
                push_req(req_wr, req_addr[24:23], req_addr[22:10], req_addr[9:0], req_len);
            end
            prev_valid = cmd_valid;
            prev_fire  = fire;
            prev_rdata = r_data;
        end
    end

    // ---------------- background drivers ----------------
    bit   ready_rand;
    logic ready_val;

    initial begin
        cmd_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            cmd_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    initial begin
        r_data = '0;
        forever begin
            @(posedge clk); #1;
            r_data = 16'($urandom);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_req(input logic wr, input logic [1:0] b, input logic [12:0] r,
                          input logic [9:0] co, input logic [11:0] l, input bit hold);
        bit got;
        got = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = {b, r, co};
        req_len   = l;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1;
                break;
            end
        end
        if (!got) check_val("req_accept_timeout", 64'(req_ready), 64'(1));
        if (!hold) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!m_busy && (exp_q.size() == 0) && !m_win_on) begin
                done = 1;
                break;
            end
        end
        @(negedge clk);
        if (!done) check_val("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic wait_cmd_valid();
        bit seen;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check_val("cmd_valid_timeout", 64'(cmd_valid), 64'(1));
    endtask

    task automatic check_all_idle(input string tag);
        check_val({tag, "_req_ready"}, 64'(req_ready), 64'(1));
        check_val({tag, "_busy"}, 64'(busy), 64'(0));
        check_val({tag, "_cmd_valid"}, 64'(cmd_valid), 64'(0));
        check_val({tag, "_cmd"}, 64'(cmd), 64'(0));
        check_val({tag, "_row"}, 64'(row_addr), 64'(0));
        check_val({tag, "_col"}, 64'(col_addr), 64'(0));
        check_val({tag, "_ba"}, 64'(cmd_ba), 64'(0));
        check_val({tag, "_rlen"}, 64'(r_cmd_len), 64'(0));
        check_val({tag, "_wlen"}, 64'(w_cmd_len), 64'(0));
        check_val({tag, "_rd_valid"}, 64'(rd_valid), 64'(0));
        check_val({tag, "_rd_last"}, 64'(rd_last), 64'(0));
        check_val({tag, "_rd_data"}, 64'(rd_data), 64'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit seen;
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
        ready_rand = 0; ready_val = 1'b1;
        #12;
        check_all_idle("reset");
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Write, single fire per command, no read window.
        do_req(1'b1, 2'd1, 13'h0123, 10'h010, 12'd7, 0);
        wait_idle();

        // Read len 3.
        do_req(1'b0, 2'd2, 13'h0456, 10'h3F0, 12'd3, 0);
        wait_idle();

        // Read at the page end: column passed through unchanged.
        do_req(1'b0, 2'd3, 13'h1FFF, 10'h3FE, 12'd5, 0);
        wait_idle();

        // ACTIVE stalled by cmd_ready = 0 for 5 cycles.
        ready_val = 1'b0;
        do_req(1'b1, 2'd3, 13'h1ABC, 10'h3FF, 12'hFFF, 0);
        wait_cmd_valid();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("stall_cmd", 64'(cmd), 64'(5));
            check_val("stall_row", 64'(row_addr), 64'(13'h1ABC));
        end
        ready_val = 1'b1;
        wait_idle();

        // Back-to-back with req_valid held high.
        do_req(1'b0, 2'd0, 13'h0AAA, 10'h155, 12'd2, 1);
        do_req(1'b1, 2'd1, 13'h1555, 10'h2AA, 12'd1, 0);
        wait_idle();

        // Random requests under random cmd_ready.
        ready_rand = 1;
        for (int n = 0; n < 16; n++) begin
            logic wr;
            wr = 1'($urandom_range(0, 1));
            do_req(wr, 2'($urandom_range(0, 3)), 13'($urandom_range(0, 8191)),
                   10'($urandom_range(0, 1023)),
                   wr ? 12'($urandom_range(0, 255)) : 12'($urandom_range(0, 9)),
                   bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                wait_idle();
                req_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_idle();
        ready_rand = 0;
        ready_val  = 1'b1;

        // Asynchronous reset in the middle of a read burst.
        do_req(1'b0, 2'd1, 13'h0F0F, 10'h00F, 12'd15, 0);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rd_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check_val("burst_start_timeout", 64'(rd_valid), 64'(1));
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_all_idle("async_rst");
        repeat (2) @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        // Write len 0.
        do_req(1'b1, 2'd2, 13'h0321, 10'h000, 12'd0, 0);
        wait_idle();

        check_val("exp_q_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #400000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete, busy=%0b expected 0", busy);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
